// File: rtl/wb_pkg.sv
// Shared definitions for the Wishbone memory slave: FSM state encoding and
// byte-offset helper.
package wb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } wb_state_t;

    // Number of address bits that select a byte within one bus word.
    function automatic int byte_off_bits(input int data_width);
        return $clog2(data_width / 8);
    endfunction

    localparam int DEFAULT_BYTE_OFF_BITS = byte_off_bits(32);

endpackage

// File: rtl/wb_mem_array.sv
// Word-organised storage with a byte-enabled write port and a registered
// read port; contents are never cleared, only the read register is reset.
module wb_mem_array #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024,
    parameter int IDX_W      = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic                    rd_en,
    input  logic [DATA_WIDTH/8-1:0] be,
    input  logic [IDX_W-1:0]        idx,
    input  logic [DATA_WIDTH-1:0]   wdat,
    output logic [DATA_WIDTH-1:0]   rdat
);

    localparam int LANES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rdat_reg;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < LANES; i++) begin
                if (be[i]) begin
                    mem[idx][i*8 +: 8] <= wdat[i*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rdat_reg <= '0;
        end else if (rd_en) begin
            rdat_reg <= mem[idx];
        end
    end

    assign rdat = rdat_reg;

endmodule

// File: rtl/wb_mem_slave.sv
// Wishbone classic memory slave with programmable wait states.
// Define WB_MEM_ERR_EN to add an err output for out-of-range addresses.
module wb_mem_slave
    import wb_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADR_WIDTH   = 32,
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADR_WIDTH-1:0]    adr,
    input  logic [DATA_WIDTH-1:0]   datwr,
    input  logic                    we,
    input  logic [DATA_WIDTH/8-1:0] sel,
    input  logic                    stb,
    input  logic                    cyc,
    output logic                    ack,
`ifdef WB_MEM_ERR_EN
    output logic                    err,
`endif
    output logic [DATA_WIDTH-1:0]   datrd
);

    localparam int OFF_W = byte_off_bits(DATA_WIDTH);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam logic [CNT_W-1:0] RELOAD = (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : '0;

    wb_state_t        state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             bad_reg, bad_next;

    logic             req;
    logic             bad_adr;
    logic             enter_ack;
    logic             mem_wr;
    logic             mem_rd;
    logic [IDX_W-1:0] idx;
    logic             unused_adr;

    assign req        = cyc & stb;
    assign idx        = adr[OFF_W +: IDX_W];
    assign unused_adr = ^adr;

`ifdef WB_MEM_ERR_EN
    // Any set bit above the word-index field points outside the array.
    assign bad_adr = (adr >> (OFF_W + IDX_W)) != '0;
`else
    assign bad_adr = 1'b0;
`endif

    // The memory access is committed on the edge that moves the FSM into ACK,
    // so a request that is aborted or reset while waiting never touches memory.
    assign enter_ack = rst && req &&
                       (((state_reg == IDLE) && (WAIT_STATES == 0)) ||
                        ((state_reg == WAIT) && (cnt_reg == '0)));
    assign mem_wr    = enter_ack &&  we && !bad_adr;
    assign mem_rd    = enter_ack && !we && !bad_adr;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        bad_next   = enter_ack ? bad_adr : bad_reg;
        case (state_reg)
            IDLE: begin
                if (req) begin
                    cnt_next   = RELOAD;
                    state_next = (WAIT_STATES == 0) ? ACK : WAIT;
                end
            end
            WAIT: begin
                if (!req) begin
                    state_next = IDLE;
                end else if (cnt_reg == '0) begin
                    state_next = ACK;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            bad_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            bad_reg   <= bad_next;
        end
    end

    assign ack = (state_reg == ACK) && !bad_reg;
`ifdef WB_MEM_ERR_EN
    assign err = (state_reg == ACK) && bad_reg;
`endif

    wb_mem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .IDX_W      (IDX_W)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .wr_en (mem_wr),
        .rd_en (mem_rd),
        .be    (sel),
        .idx   (idx),
        .wdat  (datwr),
        .rdat  (datrd)
    );

endmodule

// File: tb/tb_wb_mem_slave.sv
// Self-checking bench for wb_mem_slave: two instances (0 and 3 wait states),
// directed vector table, random traffic against a word/byte-lane model, corner cases.
module tb_wb_mem_slave;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        cyc_s [2];
    logic        stb_s [2];
    logic        we_s  [2];
    logic        ack_s [2];
    logic [31:0] adr_s [2];
    logic [31:0] dw_s  [2];
    logic [31:0] dr_s  [2];
    logic [3:0]  sel_s [2];
`ifdef WB_MEM_ERR_EN
    logic        err_s [2];
`endif

    wb_mem_slave #(.DATA_WIDTH(32), .ADR_WIDTH(32), .DEPTH(1024), .WAIT_STATES(0)) u_ws0 (
        .clk(clk), .rst(rst), .adr(adr_s[0]), .datwr(dw_s[0]), .we(we_s[0]),
        .sel(sel_s[0]), .stb(stb_s[0]), .cyc(cyc_s[0]), .ack(ack_s[0]),
`ifdef WB_MEM_ERR_EN
        .err(err_s[0]),
`endif
        .datrd(dr_s[0]));

    wb_mem_slave #(.DATA_WIDTH(32), .ADR_WIDTH(32), .DEPTH(1024), .WAIT_STATES(3)) u_ws3 (
        .clk(clk), .rst(rst), .adr(adr_s[1]), .datwr(dw_s[1]), .we(we_s[1]),
        .sel(sel_s[1]), .stb(stb_s[1]), .cyc(cyc_s[1]), .ack(ack_s[1]),
`ifdef WB_MEM_ERR_EN
        .err(err_s[1]),
`endif
        .datrd(dr_s[1]));

    int total  = 0;
    int passed = 0;

    typedef struct {
        bit          w;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        logic [31:0] exp;
        bit          exp_err;
    } vec_t;

    vec_t        vecs [11];
    logic [31:0] last_rd [2];
    logic [31:0] model [2][8];

    function automatic int ws_of(input int k);
        return (k == 0) ? 0 : 3;
    endfunction

    function automatic logic term_of(input int k);
`ifdef WB_MEM_ERR_EN
        return ack_s[k] | err_s[k];
`else
        return ack_s[k];
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else passed++;
    endtask

    // Caller must be at a negedge; returns at a negedge one cycle after the ack.
    task automatic xfer(input int k, input bit w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, output logic [31:0] rd, output int lat,
                        output bit was_err);
        cyc_s[k] = 1'b1; stb_s[k] = 1'b1; we_s[k] = w;
        adr_s[k] = a; dw_s[k] = d; sel_s[k] = s;
        lat = 0;
        was_err = 1'b0;
        forever begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (term_of(k) || lat > 40) break;
        end
        rd = dr_s[k];
`ifdef WB_MEM_ERR_EN
        was_err = err_s[k];
`endif
        $display("inst%0d %s adr=%h dat=%h sel=%h -> rd=%h lat=%0d err=%0d",
                 k, w ? "WR" : "RD", a, d, s, rd, lat, was_err);
        cyc_s[k] = 1'b0; stb_s[k] = 1'b0; we_s[k] = 1'b0;
        @(negedge clk);
        check("ack_pulse", {31'd0, term_of(k)}, 32'd0);
    endtask

    task automatic run_op(input int k, input bit w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic [31:0] exp, input bit exp_err);
        logic [31:0] rd;
        int          lat;
        bit          e;
        xfer(k, w, a, d, s, rd, lat, e);
        check("latency", lat, ws_of(k) + 1);
        if (w || exp_err) begin
            check("datrd_hold", rd, last_rd[k]);
        end else begin
            check("read_data", rd, exp);
            last_rd[k] = exp;
        end
`ifdef WB_MEM_ERR_EN
        check("err_flag", {31'd0, e}, {31'd0, exp_err});
`endif
    endtask

    initial begin
        int  seen;
        bit  adr_err;
        logic [31:0] wrap_exp;

`ifdef WB_MEM_ERR_EN
        adr_err  = 1'b1;
        wrap_exp = 32'h01020304;
`else
        adr_err  = 1'b0;
        wrap_exp = 32'hCAFEF00D;
`endif
        vecs[0]  = '{1'b1, 32'h10,   32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
        vecs[1]  = '{1'b0, 32'h10,   32'h0,        4'hF, 32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b0, 32'h13,   32'h0,        4'h1, 32'hDEADBEEF, 1'b0};
        vecs[3]  = '{1'b1, 32'h20,   32'h11223344, 4'hF, 32'h0,        1'b0};
        vecs[4]  = '{1'b1, 32'h20,   32'hAABBCCDD, 4'h5, 32'h0,        1'b0};
        vecs[5]  = '{1'b0, 32'h20,   32'h0,        4'h0, 32'h11BB33DD, 1'b0};
        vecs[6]  = '{1'b1, 32'h0,    32'h01020304, 4'hF, 32'h0,        1'b0};
        vecs[7]  = '{1'b1, 32'h1000, 32'hCAFEF00D, 4'hF, 32'h0,        adr_err};
        vecs[8]  = '{1'b0, 32'h0,    32'h0,        4'hF, wrap_exp,     1'b0};
        vecs[9]  = '{1'b1, 32'h20,   32'hFFFFFFFF, 4'h0, 32'h0,        1'b0};
        vecs[10] = '{1'b0, 32'h22,   32'h0,        4'hF, 32'h11BB33DD, 1'b0};

        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            cyc_s[k] = 1'b0; stb_s[k] = 1'b0; we_s[k] = 1'b0;
            adr_s[k] = '0; dw_s[k] = '0; sel_s[k] = '0;
            last_rd[k] = '0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("reset_ack", {31'd0, term_of(k)}, 32'd0);
            check("reset_datrd", dr_s[k], 32'd0);
        end
        rst = 1'b1;

        for (int k = 0; k < 2; k++) begin
            for (int v = 0; v < 11; v++) begin
                run_op(k, vecs[v].w, vecs[v].a, vecs[v].d, vecs[v].s, vecs[v].exp, vecs[v].exp_err);
            end
        end

        // Random traffic in an 8-word window starting at byte 0x100.
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 8; i++) begin
                model[k][i] = $urandom;
                run_op(k, 1'b1, 32'h100 + 32'(i * 4), model[k][i], 4'hF, 32'h0, 1'b0);
            end
            for (int n = 0; n < 40; n++) begin
                int          i;
                bit          w;
                logic [31:0] a, d;
                logic [3:0]  s;
                i = $urandom_range(0, 7);
                w = 1'($urandom_range(0, 1));
                a = 32'h100 + 32'(i * 4) + 32'($urandom_range(0, 3));
                d = $urandom;
                s = 4'($urandom_range(0, 15));
                if (w) begin
                    run_op(k, 1'b1, a, d, s, 32'h0, 1'b0);
                    for (int b = 0; b < 4; b++)
                        if (s[b]) model[k][i][b*8 +: 8] = d[b*8 +: 8];
                end else begin
                    run_op(k, 1'b0, a, 32'h0, s, model[k][i], 1'b0);
                end
            end
        end

        // Abort: write to 0x40 loses stb after one wait cycle.
        run_op(1, 1'b1, 32'h40, 32'h0BADF00D, 4'hF, 32'h0, 1'b0);
        cyc_s[1] = 1'b1; stb_s[1] = 1'b1; we_s[1] = 1'b1;
        adr_s[1] = 32'h40; dw_s[1] = 32'h12345678; sel_s[1] = 4'hF;
        seen = 0;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            if (term_of(1)) seen++;
        end
        stb_s[1] = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (term_of(1)) seen++;
        end
        cyc_s[1] = 1'b0; we_s[1] = 1'b0;
        $display("inst1 ABORT WR adr=00000040 dat=12345678 acks_seen=%0d", seen);
        check("abort_noack", seen, 0);
        run_op(1, 1'b0, 32'h40, 32'h0, 4'hF, 32'h0BADF00D, 1'b0);

        // Reset during the wait phase of a write.
        cyc_s[1] = 1'b1; stb_s[1] = 1'b1; we_s[1] = 1'b1;
        adr_s[1] = 32'h40; dw_s[1] = 32'h55AA55AA; sel_s[1] = 4'hF;
        seen = 0;
        @(posedge clk);
        @(negedge clk);
        if (term_of(1)) seen++;
        rst = 1'b0;
        cyc_s[1] = 1'b0; stb_s[1] = 1'b0; we_s[1] = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (term_of(1)) seen++;
        end
        $display("inst1 RESET during WR adr=00000040 acks_seen=%0d", seen);
        check("reset_noack", seen, 0);
        check("reset_datrd0", dr_s[0], 32'd0);
        check("reset_datrd1", dr_s[1], 32'd0);
        last_rd[0] = '0;
        last_rd[1] = '0;
        rst = 1'b1;
        run_op(1, 1'b0, 32'h40, 32'h0, 4'hF, 32'h0BADF00D, 1'b0);
        run_op(0, 1'b0, 32'h10, 32'h0, 4'hF, 32'hDEADBEEF, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/wb_mem_slave.md
WB_MEM_SLAVE -- requirements
Module: wb_mem_slave

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning bus data width in bits (multiple of 8).
REQ-002 The block SHALL have parameter ADR_WIDTH, default 32, meaning byte-address width.
REQ-003 The block SHALL have parameter DEPTH, default 1024, meaning number of DATA_WIDTH words stored (power of two).
REQ-004 The block SHALL have parameter WAIT_STATES, default 0, meaning idle cycles inserted before ack (0..15).
REQ-005 The block SHALL have port clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port rst, input, 1, meaning reset; synchronous, active-low.
REQ-007 The block SHALL have port adr, input, ADR_WIDTH, meaning byte address.
REQ-008 The block SHALL have port datwr, input, DATA_WIDTH, meaning write data.
REQ-009 The block SHALL have port we, input, 1, meaning write enable (1 = write, 0 = read).
REQ-010 The block SHALL have port sel, input, DATA_WIDTH/8, meaning byte lane select.
REQ-011 The block SHALL have port stb, input, 1, meaning strobe.
REQ-012 The block SHALL have port cyc, input, 1, meaning bus cycle valid.
REQ-013 The block SHALL have port ack, output, 1, meaning transfer complete.
REQ-014 The block SHALL have port datrd, output, DATA_WIDTH, meaning read data.

Function
REQ-015 The block SHALL implement a Wishbone classic (non-pipelined) slave; a request exists when cyc=1 and stb=1.
REQ-016 The block SHALL use word index adr[log2(DATA_WIDTH/8)+log2(DEPTH)-1 : log2(DATA_WIDTH/8)]; the low byte-offset bits SHALL be ignored.
REQ-017 The block SHALL have FSM states IDLE, WAIT and ACK.
REQ-018 FSM transitions SHALL be: IDLE -> WAIT on request when WAIT_STATES>0; IDLE -> ACK on request when WAIT_STATES=0; WAIT -> ACK after WAIT_STATES cycles; ACK -> IDLE unconditionally.
REQ-019 Latency: a request first sampled at edge T SHALL produce ack=1 for exactly one cycle after edge T+WAIT_STATES.
REQ-020 ack SHALL be 0 for at least one cycle between transfers, so back-to-back requests complete every WAIT_STATES+2 cycles.
REQ-021 Write: on the ack cycle the memory SHALL update only lanes with sel[i]=1; lanes with sel[i]=0 SHALL retain their previous value.
REQ-022 Read: datrd SHALL be registered, valid while ack=1, and held unchanged until the next read ack; sel SHALL NOT mask read data.
REQ-023 Abort: if cyc or stb drops in WAIT, the FSM SHALL return to IDLE with no ack and no memory write.
REQ-024 Without the REQ-031 feature, addresses beyond DEPTH words SHALL wrap modulo DEPTH.
REQ-025 The wait-state counter SHALL be ceil(log2(WAIT_STATES+1)) bits wide (minimum 1 bit) and reload on every IDLE exit.

Reset
REQ-026 While rst=0 at a clock edge, the block SHALL force FSM=IDLE, ack=0, datrd=0 and counter=0.
REQ-027 Reset asserted mid-transfer SHALL cancel the transfer with no ack and no write.
REQ-028 Memory contents SHALL NOT be cleared by reset.
REQ-029 After reset release, the first request SHALL be accepted at the next edge.

Configuration
REQ-030 Macro WB_MEM_ERR_EN SHALL select error-response behaviour.
REQ-031 With WB_MEM_ERR_EN defined, the block SHALL add output err (1 bit, reset 0); an access whose word index is >= DEPTH, or whose adr bits above the index range are non-zero, SHALL get err=1 instead of ack=1, at the same cycle timing, with no write and datrd unchanged.
REQ-032 Without WB_MEM_ERR_EN, port err SHALL be absent and the REQ-024 wrap applies.

Structure
REQ-033 Package wb_pkg SHALL hold the FSM state enum (IDLE/WAIT/ACK) and the helper constant for byte-offset bit count.
REQ-034 Storage SHALL live in sub-module wb_mem_array: one write port with byte enables and one registered read port.

Verification
REQ-035 With WAIT_STATES=0: write 0xDEADBEEF to adr 0x10 with sel=0xF, then read 0x10 -> ack 1 cycle after each request and datrd=0xDEADBEEF.
REQ-036 Starting from word 0x11223344 at 0x20: write 0xAABBCCDD with sel=0x5, then read 0x20 -> datrd=0x11BB33DD.
REQ-037 With WAIT_STATES=3: a read request at edge T -> ack high only in the cycle after edge T+3.
REQ-038 With WAIT_STATES=3: drop stb after 1 wait cycle of a write of 0x12345678 to 0x40 -> no ack, and a read of 0x40 returns the old value.
REQ-039 With DEPTH=1024: write 0xCAFEF00D to byte adr 0x1000 -> a read of adr 0x0 returns 0xCAFEF00D without WB_MEM_ERR_EN; with WB_MEM_ERR_EN, err=1, ack=0 and adr 0x0 is unchanged.
REQ-040 Assert rst=0 during WAIT of a write -> ack stays 0, no write occurs, and the next request after release completes normally.
